// File: rtl/dwarf_leb128_decoder.sv
// rtl/dwarf_leb128_decoder.sv - byte-stream ULEB128/SLEB128 operand decoder with valid/ready output
module dwarf_leb128_decoder #(
  parameter int MAX_BYTES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        signed_mode,
  input  logic [31:0] wr_data,
  input  logic [1:0]  wr_n,
  output logic        wr_ready,
  output logic        drop_err,
  output logic        val_valid,
  input  logic        val_ready,
  output logic [31:0] val_data,
  output logic [2:0]  val_nbytes,
  output logic        val_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_ready_q, wr_ready_d;
  logic        drop_err_q, drop_err_d;
  logic [31:0] acc_q, acc_d;
  logic [2:0]  nb_q, nb_d;
  logic        sgn_q, sgn_d;
  logic        ovf_q, ovf_d;
  logic        val_valid_q, val_valid_d;
  logic [31:0] val_data_q, val_data_d;
  logic [2:0]  val_nbytes_q, val_nbytes_d;
  logic        val_ovf_q, val_ovf_d;

  // Per-byte decode terms for the byte at the head of the buffer
  logic        accept, consume, is_idle;
  logic [7:0]  b;
  logic [2:0]  k;
  logic        sgn_n, ovf_n, fill;
  logic [5:0]  sh, fill_sh;
  logic [31:0] base, acc_n, mask;
  logic [2:0]  nb_n;

  // Next-state: write acceptance, byte consumption, LEB128 accumulation, handshake, flush
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    drop_err_d   = drop_err_q;
    acc_d        = acc_q;
    nb_d         = nb_q;
    sgn_d        = sgn_q;
    ovf_d        = ovf_q;
    val_valid_d  = val_valid_q;
    val_data_d   = val_data_q;
    val_nbytes_d = val_nbytes_q;
    val_ovf_d    = val_ovf_q;

    accept  = (wr_n != 2'b11) && wr_ready_q;
    consume = (cnt_q != 3'd0) && (state_q != S_HOLD);
    is_idle = (state_q == S_IDLE);

    // A new value starts from a clean accumulator and samples the signedness once
    b     = buf_q[7:0];
    k     = is_idle ? 3'd0 : nb_q;
    sgn_n = is_idle ? signed_mode : sgn_q;
    base  = is_idle ? 32'd0 : acc_q;
    ovf_n = is_idle ? 1'b0 : ovf_q;

    sh      = {3'b000, k} * 6'd7;
    fill_sh = sh + 6'd7;
    mask    = 32'hFFFF_FFFF << fill_sh;
    acc_n   = base;
    if (int'(k) < MAX_BYTES) begin
      acc_n = base | ({25'd0, b[6:0]} << sh);
    end else begin
      ovf_n = 1'b1;
    end
    // Fifth byte carries only 4 meaningful bits; the rest must be zero or sign copies
    if (k == 3'd4) begin
      if (!sgn_n && (b[6:4] != 3'b000)) ovf_n = 1'b1;
      if (sgn_n && (b[6:3] != 4'b0000) && (b[6:3] != 4'b1111)) ovf_n = 1'b1;
    end
    nb_n = (k == 3'd7) ? 3'd7 : k + 3'd1;
    fill = sgn_n && b[6] && (fill_sh < 6'd32);

    if (consume) begin
      buf_d = buf_q >> 8;
      cnt_d = cnt_q - 3'd1;
      acc_d = acc_n;
      nb_d  = nb_n;
      sgn_d = sgn_n;
      ovf_d = ovf_n;
      if (b[7]) begin
        state_d = S_ACCUM;
      end else begin
        state_d      = S_HOLD;
        val_valid_d  = 1'b1;
        val_data_d   = fill ? (acc_n | mask) : acc_n;
        val_nbytes_d = nb_n;
        val_ovf_d    = ovf_n;
      end
    end

    if ((state_q == S_HOLD) && val_ready) begin
      state_d     = S_IDLE;
      val_valid_d = 1'b0;
    end

    // Acceptance only happens with an empty buffer, so it never collides with consumption
    if (accept) begin
      buf_d = wr_data;
      case (wr_n)
        2'b00:   cnt_d = 3'd1;
        2'b01:   cnt_d = 3'd2;
        default: cnt_d = 3'd4;
      endcase
    end
    if ((wr_n != 2'b11) && !wr_ready_q) drop_err_d = 1'b1;

    if (flush) begin
      state_d      = S_IDLE;
      buf_d        = 32'd0;
      cnt_d        = 3'd0;
      drop_err_d   = 1'b0;
      acc_d        = 32'd0;
      nb_d         = 3'd0;
      sgn_d        = 1'b0;
      ovf_d        = 1'b0;
      val_valid_d  = 1'b0;
      val_data_d   = 32'd0;
      val_nbytes_d = 3'd0;
      val_ovf_d    = 1'b0;
    end

    wr_ready_d = (cnt_d == 3'd0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      buf_q        <= 32'd0;
      cnt_q        <= 3'd0;
      wr_ready_q   <= 1'b1;
      drop_err_q   <= 1'b0;
      acc_q        <= 32'd0;
      nb_q         <= 3'd0;
      sgn_q        <= 1'b0;
      ovf_q        <= 1'b0;
      val_valid_q  <= 1'b0;
      val_data_q   <= 32'd0;
      val_nbytes_q <= 3'd0;
      val_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      wr_ready_q   <= wr_ready_d;
      drop_err_q   <= drop_err_d;
      acc_q        <= acc_d;
      nb_q         <= nb_d;
      sgn_q        <= sgn_d;
      ovf_q        <= ovf_d;
      val_valid_q  <= val_valid_d;
      val_data_q   <= val_data_d;
      val_nbytes_q <= val_nbytes_d;
      val_ovf_q    <= val_ovf_d;
    end
  end

  assign wr_ready     = wr_ready_q;
  assign drop_err     = drop_err_q;
  assign val_valid    = val_valid_q;
  assign val_data     = val_data_q;
  assign val_nbytes   = val_nbytes_q;
  assign val_overflow = val_ovf_q;

endmodule

// File: tb/tb_dwarf_leb128_decoder.sv
// tb/tb_dwarf_leb128_decoder.sv - directed self-checking bench for dwarf_leb128_decoder
module tb_dwarf_leb128_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        signed_mode = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic [1:0]  wr_n = 2'b11;
  logic        wr_ready;
  logic        drop_err;
  logic        val_valid;
  logic        val_ready = 1'b1;
  logic [31:0] val_data;
  logic [2:0]  val_nbytes;
  logic        val_overflow;

  int passed = 0;
  int total  = 0;

  dwarf_leb128_decoder #(.MAX_BYTES(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .signed_mode  (signed_mode),
    .wr_data      (wr_data),
    .wr_n         (wr_n),
    .wr_ready     (wr_ready),
    .drop_err     (drop_err),
    .val_valid    (val_valid),
    .val_ready    (val_ready),
    .val_data     (val_data),
    .val_nbytes   (val_nbytes),
    .val_overflow (val_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for an empty buffer, then issue one write for a single cycle
  task automatic wr(input logic [1:0] n, input logic [31:0] d);
    int t = 0;
    while (!wr_ready && t < 50) begin
      tick();
      t++;
    end
    chk("wr_ready_wait", {31'd0, wr_ready}, 32'd1);
    wr_n    = n;
    wr_data = d;
    tick();
    wr_n = 2'b11;
  endtask

  // Wait (bounded) for the next value, check it, then let the handshake edge pass
  task automatic expect_val(input string tag, input logic [31:0] d, input logic [2:0] nb, input logic ov);
    int t = 0;
    while (!val_valid && t < 50) begin
      tick();
      t++;
    end
    chk({tag, "_valid"}, {31'd0, val_valid}, 32'd1);
    chk({tag, "_data"}, val_data, d);
    chk({tag, "_nbytes"}, {29'd0, val_nbytes}, {29'd0, nb});
    chk({tag, "_ovf"}, {31'd0, val_overflow}, {31'd0, ov});
    tick();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_drop_err", {31'd0, drop_err}, 32'd0);
    chk("rst_val_valid", {31'd0, val_valid}, 32'd0);
    chk("rst_val_data", val_data, 32'd0);
    chk("rst_val_nbytes", {29'd0, val_nbytes}, 32'd0);
    chk("rst_val_ovf", {31'd0, val_overflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Unsigned single-byte writes E5 8E 26
    wr(2'b00, 32'h0000_00E5);
    wr(2'b00, 32'h0000_008E);
    wr(2'b00, 32'h0000_0026);
    expect_val("u3", 32'h0009_8765, 3'd3, 1'b0);

    // One 4-byte write holding a full value and the start of the next
    wr(2'b10, 32'h0026_8EE5);
    chk("w4_ready_low0", {31'd0, wr_ready}, 32'd0);
    expect_val("w4a", 32'h0009_8765, 3'd3, 1'b0);
    chk("w4_ready_low1", {31'd0, wr_ready}, 32'd0);
    expect_val("w4b", 32'h0000_0000, 3'd1, 1'b0);
    chk("w4_ready_high", {31'd0, wr_ready}, 32'd1);

    // Signed values
    signed_mode = 1'b1;
    wr(2'b00, 32'h0000_007F);
    expect_val("s1", 32'hFFFF_FFFF, 3'd1, 1'b0);
    wr(2'b00, 32'h0000_00C0);
    wr(2'b00, 32'h0000_00BB);
    wr(2'b00, 32'h0000_0078);
    expect_val("s3", 32'hFFFE_1DC0, 3'd3, 1'b0);
    signed_mode = 1'b0;

    // Five-byte boundary and overflow cases
    wr(2'b10, 32'hFFFF_FFFF);
    wr(2'b00, 32'h0000_000F);
    expect_val("u5max", 32'hFFFF_FFFF, 3'd5, 1'b0);
    wr(2'b10, 32'hFFFF_FFFF);
    wr(2'b00, 32'h0000_001F);
    expect_val("u5ovf", 32'hFFFF_FFFF, 3'd5, 1'b1);
    wr(2'b10, 32'h8080_8080);
    wr(2'b00, 32'h0000_0080);
    wr(2'b00, 32'h0000_0001);
    expect_val("u6ovf", 32'h0000_0000, 3'd6, 1'b1);

    // Back-pressure: two values buffered, consumer stalls for 10 cycles
    val_ready = 1'b0;
    wr(2'b01, 32'h0000_0305);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", {31'd0, val_valid}, 32'd1);
      chk("hold_data", val_data, 32'd5);
    end
    chk("hold_ready_low", {31'd0, wr_ready}, 32'd0);
    wr_n    = 2'b00;
    wr_data = 32'h0000_007F;
    tick();
    wr_n = 2'b11;
    chk("drop_err_set", {31'd0, drop_err}, 32'd1);
    val_ready = 1'b1;
    expect_val("hold_a", 32'h0000_0005, 3'd1, 1'b0);
    expect_val("hold_b", 32'h0000_0003, 3'd1, 1'b0);
    repeat (4) tick();
    chk("no_dropped_val", {31'd0, val_valid}, 32'd0);
    chk("drop_err_sticky", {31'd0, drop_err}, 32'd1);

    // Flush mid-value together with a write
    wr(2'b00, 32'h0000_00E5);
    wr(2'b00, 32'h0000_008E);
    tick();
    flush   = 1'b1;
    wr_n    = 2'b00;
    wr_data = 32'h0000_0011;
    tick();
    flush = 1'b0;
    wr_n  = 2'b11;
    chk("fl_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("fl_drop_err", {31'd0, drop_err}, 32'd0);
    chk("fl_val_valid", {31'd0, val_valid}, 32'd0);
    chk("fl_val_data", val_data, 32'd0);
    repeat (3) tick();
    chk("fl_write_discarded", {31'd0, val_valid}, 32'd0);
    wr(2'b00, 32'h0000_0005);
    expect_val("fl_after", 32'h0000_0005, 3'd1, 1'b0);

    // Asynchronous reset mid-value with drop_err and val_data non-zero
    wr(2'b00, 32'h0000_00E5);
    wr_n    = 2'b00;
    wr_data = 32'h0000_0001;
    tick();
    wr_n = 2'b11;
    chk("pre_rst_drop", {31'd0, drop_err}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("arst_drop_err", {31'd0, drop_err}, 32'd0);
    chk("arst_val_valid", {31'd0, val_valid}, 32'd0);
    chk("arst_val_data", val_data, 32'd0);
    chk("arst_val_nbytes", {29'd0, val_nbytes}, 32'd0);
    chk("arst_val_ovf", {31'd0, val_overflow}, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    wr(2'b00, 32'h0000_0005);
    expect_val("arst_after", 32'h0000_0005, 3'd1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dwarf_leb128_decoder.md
Name: dwarf_leb128_decoder

Overview:
- Front-end stage that feeds the DWARF5 line-table accelerator's line-program state machine.
- Accepts little-endian byte streams in 8/16/32-bit writes, using the same `write_n` width encoding as the peripheral register bus.
- Unpacks each write into bytes and decodes ULEB128/SLEB128 operands into 32-bit values.
- Presents each decoded value on a valid/ready output to the opcode sequencer.

Parameters:
- MAX_BYTES, 5, number of LEB128 bytes that can contribute bits to a 32-bit result; longer sequences are flagged as overflow.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- flush  input  1  synchronous clear of all buffered and partial state
- signed_mode  input  1  0=ULEB128, 1=SLEB128; sampled when the first byte of a value is consumed
- wr_data  input  32  write data, byte 0 = bits [7:0]
- wr_n  input  2  11=no write, 00=1 byte, 01=2 bytes, 10=4 bytes
- wr_ready  output  1  byte buffer empty, write accepted this cycle
- drop_err  output  1  sticky: a write arrived while wr_ready=0
- val_valid  output  1  decoded value available
- val_ready  input  1  consumer accepts the value
- val_data  output  32  decoded value
- val_nbytes  output  3  encoded length, saturating at 7
- val_overflow  output  1  value exceeded 32 bits or MAX_BYTES

Behaviour:
- Reset (async, rst_n=0): buffer empty, state IDLE; wr_ready=1, drop_err=0, val_valid=0, val_data=0, val_nbytes=0, val_overflow=0.
- Write handling
  - A write is accepted when wr_n!=11 and wr_ready=1. Bytes are loaded into a 4-byte buffer with count 1, 2 or 4. wr_n=11 is ignored.
  - wr_ready = (buffer count==0), registered. It drops the cycle after acceptance.
  - A write with wr_ready=0 is discarded and sets drop_err.
- Byte consumption
  - At most one byte is consumed per cycle, lowest byte first.
  - A byte is consumed when count>0 and state!=HOLD.
  - A byte arriving in a write is consumed at the earliest in the cycle after acceptance.
- States
  - IDLE: no partial value. Consuming a byte latches signed_mode, sets shift=0, clears the accumulator, then processes the byte as in ACCUM.
  - ACCUM: each consumed byte b, at byte index k starting at 0:
    - If k<MAX_BYTES, b[6:0] is ORed into the accumulator at bit 7k; bits above bit 31 are dropped.
    - nbytes increments, saturating at 7.
    - If k==4 and unsigned, overflow is set when b[6:4]!=0.
    - If k==4 and signed, overflow is set when b[6:3] is not all equal.
    - If k>=MAX_BYTES, overflow is set and b[6:0] is ignored.
    - b[7]=1 stays in ACCUM. b[7]=0 goes to HOLD.
  - On termination in signed mode with b[6]=1 and 7(k+1)<32, bits [31:7(k+1)] are filled with ones.
  - HOLD: val_valid=1; val_data, val_nbytes and val_overflow are stable. Byte consumption stalls.
    - val_valid&&val_ready returns to IDLE the next cycle.
    - Buffered bytes resume consumption in that IDLE cycle.
- Latency
  - The terminating byte consumed in cycle t gives val_valid=1 in cycle t+1.
  - Throughput is 1 byte/cycle, plus 1 bubble cycle per value (the HOLD→IDLE handshake cycle).
- Value boundaries
  - A value may span multiple writes; the accumulator persists across buffer refills.
  - A 4-byte write may hold the tail of one value and the start of the next.
- flush
  - Next cycle: buffer empty, IDLE, val_valid=0, drop_err=0. Output data registers are zeroed.
  - flush has priority over a simultaneous write (the write is discarded without setting drop_err) and over a simultaneous val_ready.
- Reset mid-value: the partial value is lost with no output; there is no recovery.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Unsigned, wr_n=00 bytes E5, 8E, 26 with val_ready=1 → one val_valid pulse: val_data=0x00098765, nbytes=3, overflow=0.
- Unsigned, wr_n=10, wr_data=0x00268EE5 → two values in order: 0x00098765 (nbytes=3), then 0x00000000 (nbytes=1). wr_ready stays low until the 4th byte is consumed.
- Signed: byte 7F → 0xFFFFFFFF, nbytes=1. Bytes C0, BB, 78 → 0xFFFE1DC0 (−123456), nbytes=3.
- Unsigned FF FF FF FF 0F → 0xFFFFFFFF, overflow=0. With fifth byte 1F instead → overflow=1. Bytes 80 ×5 then 01 → overflow=1, nbytes=6.
- Hold val_ready=0 for 10 cycles with two values buffered → val_data stable, no bytes consumed. Second write while wr_ready=0 → drop_err=1, write discarded.
- flush asserted mid-value (after 8E) together with a write → next cycle IDLE, wr_ready=1, drop_err=0, val_valid=0. Then byte 05 → val_data=5, nbytes=1. Async rst_n pulse mid-value → all outputs return to reset values immediately.
